tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive-side counterpart of a TDM multiplexer that serialises LANES parallel words onto one shared bus.
- Accepts a framed stream of words marked with a start-of-frame flag and steers each word to its own lane holding register.
- Signals each lane write, each completed frame, and each framing error.
- Sits between a serial/shared link and per-channel consumers.

Parameters:
- WIDTH, 8, bits per data word.
- LANES, 4, words per frame / number of output lanes; legal range 2..16.
- CNT_W, $clog2(LANES), localparam; width of the lane counter.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_data/in_sof qualify this cycle.
- in_sof  input  1  word is lane 0 of a frame; ignored when in_valid=0.
- in_data  input  WIDTH  multiplexed data word.
- lane_data  output  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; registered.
- lane_strb  output  LANES  one-hot, 1-cycle pulse marking the lane written.
- frame_done  output  1  1-cycle pulse when lane LANES-1 is written in sequence.
- sync_err  output  1  1-cycle pulse on a framing violation.
- locked  output  1  high while in SYNC state.

Behaviour:
- Reset: one clock, synchronous and active-low.
  - Every flop clears on any rising edge with rst_n=0: lane_data=0, lane_strb=0, frame_done=0, sync_err=0, locked=0, lane counter cnt=0, state=HUNT.
  - Reset mid-frame discards the partial frame; lanes already written are also cleared.
- FSM states: HUNT and SYNC.
- HUNT:
  - in_valid=1, in_sof=0: word dropped, no outputs change.
  - in_valid=1, in_sof=1: write lane 0, set lane_strb[0], cnt<=1, state<=SYNC, locked<=1.
- SYNC, in_valid=1, no violation: write lane cnt and pulse lane_strb[cnt].
  - If cnt==LANES-1: pulse frame_done, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- SYNC violation, early SOF (in_sof=1 with cnt!=0):
  - Pulse sync_err.
  - Treat the word as a new lane 0: write lane 0, pulse lane_strb[0], cnt<=1.
  - Stay in SYNC, no frame_done.
- SYNC violation, missing SOF (in_sof=0 with cnt==0):
  - Pulse sync_err and drop the word.
  - state<=HUNT, locked<=0, cnt<=0, no strobe.
- SYNC, in_valid=0: cnt holds, no pulses. Gaps of any length inside a frame are legal.
- Latency: one cycle from the accepting edge to the updated lane_data and the strobe/frame_done/sync_err pulse.
- Lanes not written in a cycle hold their value; lane_data never returns to 0 except on reset.
- Back-to-back frames at full rate (in_valid held high) produce frame_done once every LANES cycles with no bubble.
- in_data and in_sof are don't-care when in_valid=0. No backpressure: the block is always ready.
- At most one of lane_strb bits is set in any cycle.
- frame_done and sync_err never assert in the same cycle.

Decomposition:
- Shared package tdm_pkg holds:
  - state typedef tdm_state_e {HUNT, SYNC};
  - constants TDM_MAX_LANES=16 and TDM_DEF_WIDTH=8, shared with the transmit-side multiplexer.
- One natural sub-module: tdm_lane_reg.
  - WIDTH-bit register with synchronous active-low clear and write enable.
  - Instantiated LANES times via generate; enable = accept & (cnt==k).

Test Plan:
- Reset then a full frame: rst_n low 2 cycles; all outputs 0.
  - Drive 0x11(sof),0x22,0x33,0x44 on consecutive cycles.
  - Expect lane_strb 0001,0010,0100,1000 one cycle later each, frame_done on the 4th, lane_data=0x44332211, locked=1.
- Hunt discard: words 0xAA,0xBB without sof, then 0x01(sof),0x02,0x03,0x04.
  - Expect no strobes for the first two, then lane_data=0x04030201 and one frame_done.
- Gaps: frame 0x10(sof),gap,0x20,gap×3,0x30,0x40.
  - Expect strobes only on valid cycles, frame_done once, lane_data=0x40302010.
- Early SOF: 0x01(sof),0x02,0x05(sof),0x06,0x07,0x08.
  - Expect sync_err pulse on the third word, lane 0=0x05, locked stays 1, frame_done after 0x08, lane_data=0x08070605.
- Missing SOF: complete frame, then 0x99 without sof.
  - Expect sync_err, locked=0, no strobe, lane_data unchanged.
  - A subsequent sof word relocks.
- Reset mid-frame: after 0x11(sof),0x22, assert rst_n low 1 cycle, then send 0x33,0x44 without sof.
  - Expect lane_data=0, locked=0, no strobes (HUNT).

Source files
------------

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg : types and constants shared by the TDM mux/demux pair
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        SYNC = 1'b1
    } tdm_state_e;

    localparam int TDM_MAX_LANES = 16;
    localparam int TDM_DEF_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/tdm_lane_reg.sv
// ---------------------------------------------------------------------------
// tdm_lane_reg : one lane holding register, write enable plus sync clear
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_lane_reg
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux : steers a framed TDM word stream into per-lane holding registers
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_DEF_WIDTH,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [WIDTH-1:0]   in_data,
    output logic [LANES*WIDTH-1:0] lane_data,
    output logic [LANES-1:0]   lane_strb,
    output logic               frame_done,
    output logic               sync_err,
    output logic               locked
);

    localparam int CNT_W = $clog2(LANES);

    tdm_state_e       r_state;
    tdm_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_wr;
    logic [CNT_W-1:0] w_wr_lane;
    logic [LANES-1:0] w_strb;
    logic             w_err;
    logic             w_done;

    logic w_early;
    logic w_miss;
    logic w_last;

    // Framing violations are only meaningful once locked.
    assign w_early = in_valid && (r_state == SYNC) && in_sof && (r_cnt != '0);
    assign w_miss  = in_valid && (r_state == SYNC) && !in_sof && (r_cnt == '0);
    assign w_last  = (r_cnt == CNT_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_cnt      <= '0;
            lane_strb  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            lane_strb  <= w_strb;
            frame_done <= w_done;
            sync_err   <= w_err;
            locked     <= (w_state_nxt == SYNC);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            HUNT: begin
                if (in_valid && in_sof) begin
                    w_state_nxt = SYNC;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            SYNC: begin
                if (w_miss) begin
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end else if (w_early) begin
                    w_cnt_nxt = CNT_W'(1);
                end else if (in_valid) begin
                    w_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_wr      = 1'b0;
        w_wr_lane = '0;
        w_err     = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            HUNT: begin
                w_wr = in_valid && in_sof;
            end
            SYNC: begin
                if (w_miss) begin
                    w_err = 1'b1;
                end else if (w_early) begin
                    // Early SOF restarts the frame at lane 0.
                    w_err = 1'b1;
                    w_wr  = 1'b1;
                end else if (in_valid) begin
                    w_wr      = 1'b1;
                    w_wr_lane = r_cnt;
                    w_done    = w_last;
                end
            end
            default: begin
                w_wr = 1'b0;
            end
        endcase
        for (int k = 0; k < LANES; k++) begin
            w_strb[k] = w_wr && (w_wr_lane == CNT_W'(k));
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            tdm_lane_reg #(
                .WIDTH (WIDTH)
            ) u_lane_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_strb[k]),
                .d     (in_data),
                .q     (lane_data[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux : directed self-checking bench for tdm_demux (4 lanes x 8 bits)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic [31:0] lane_data;
    logic [3:0]  lane_strb;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux #(
        .WIDTH (8),
        .LANES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .lane_data  (lane_data),
        .lane_strb  (lane_strb),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word, then land 1 time unit after the accepting edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] strb,
                              input logic done, input logic err, input logic lk);
        check({tag, ".strb"},   {60'd0, lane_strb}, {60'd0, strb});
        check({tag, ".done"},   {63'd0, frame_done}, {63'd0, done});
        check({tag, ".err"},    {63'd0, sync_err},  {63'd0, err});
        check({tag, ".locked"}, {63'd0, locked},    {63'd0, lk});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        check("reset.data", {32'd0, lane_data}, 64'd0);
        expect_out("reset", 4'b0000, 0, 0, 0);
        rst_n = 1'b1;

        // Full frame at full rate
        step(1, 1, 8'h11); expect_out("f1.w0", 4'b0001, 0, 0, 1);
        step(1, 0, 8'h22); expect_out("f1.w1", 4'b0010, 0, 0, 1);
        step(1, 0, 8'h33); expect_out("f1.w2", 4'b0100, 0, 0, 1);
        step(1, 0, 8'h44); expect_out("f1.w3", 4'b1000, 1, 0, 1);
        check("f1.data", {32'd0, lane_data}, 64'h44332211);
        step(0, 0, 8'hFF); expect_out("f1.idle", 4'b0000, 0, 0, 1);

        // Non-SOF word at frame boundary drops lock, next is silently dropped in HUNT
        step(1, 0, 8'hAA); expect_out("hunt.aa", 4'b0000, 0, 1, 0);
        step(1, 0, 8'hBB); expect_out("hunt.bb", 4'b0000, 0, 0, 0);
        check("hunt.hold", {32'd0, lane_data}, 64'h44332211);
        step(1, 1, 8'h01); expect_out("hunt.w0", 4'b0001, 0, 0, 1);
        step(1, 0, 8'h02); expect_out("hunt.w1", 4'b0010, 0, 0, 1);
        step(1, 0, 8'h03); expect_out("hunt.w2", 4'b0100, 0, 0, 1);
        step(1, 0, 8'h04); expect_out("hunt.w3", 4'b1000, 1, 0, 1);
        check("hunt.data", {32'd0, lane_data}, 64'h04030201);

        // Gaps inside a frame
        step(1, 1, 8'h10); expect_out("gap.w0", 4'b0001, 0, 0, 1);
        step(0, 1, 8'hEE); expect_out("gap.g0", 4'b0000, 0, 0, 1);
        step(1, 0, 8'h20); expect_out("gap.w1", 4'b0010, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hDD); expect_out("gap.g1", 4'b0000, 0, 0, 1);
        end
        step(1, 0, 8'h30); expect_out("gap.w2", 4'b0100, 0, 0, 1);
        step(1, 0, 8'h40); expect_out("gap.w3", 4'b1000, 1, 0, 1);
        check("gap.data", {32'd0, lane_data}, 64'h40302010);

        // Early SOF restarts the frame
        step(1, 1, 8'h01); expect_out("early.w0", 4'b0001, 0, 0, 1);
        step(1, 0, 8'h02); expect_out("early.w1", 4'b0010, 0, 0, 1);
        step(1, 1, 8'h05); expect_out("early.sof", 4'b0001, 0, 1, 1);
        check("early.lane0", {32'd0, lane_data}, 64'h40300205);
        step(1, 0, 8'h06); expect_out("early.w1b", 4'b0010, 0, 0, 1);
        step(1, 0, 8'h07); expect_out("early.w2", 4'b0100, 0, 0, 1);
        step(1, 0, 8'h08); expect_out("early.w3", 4'b1000, 1, 0, 1);
        check("early.data", {32'd0, lane_data}, 64'h08070605);

        // Missing SOF, then relock
        step(1, 0, 8'h99); expect_out("miss", 4'b0000, 0, 1, 0);
        check("miss.data", {32'd0, lane_data}, 64'h08070605);
        step(1, 1, 8'h5A); expect_out("relock.w0", 4'b0001, 0, 0, 1);
        step(1, 0, 8'h5B); expect_out("relock.w1", 4'b0010, 0, 0, 1);
        step(1, 0, 8'h5C); expect_out("relock.w2", 4'b0100, 0, 0, 1);
        step(1, 0, 8'h5D); expect_out("relock.w3", 4'b1000, 1, 0, 1);
        check("relock.data", {32'd0, lane_data}, 64'h5D5C5B5A);

        // Reset mid-frame
        step(1, 1, 8'h11); expect_out("mid.w0", 4'b0001, 0, 0, 1);
        step(1, 0, 8'h22); expect_out("mid.w1", 4'b0010, 0, 0, 1);
        check("mid.partial", {32'd0, lane_data}, 64'h5D5C2211);
        rst_n = 1'b0;
        step(0, 0, 8'h00);
        check("mid.rst.data", {32'd0, lane_data}, 64'd0);
        expect_out("mid.rst", 4'b0000, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 0, 8'h33); expect_out("mid.w2", 4'b0000, 0, 0, 0);
        step(1, 0, 8'h44); expect_out("mid.w3", 4'b0000, 0, 0, 0);
        check("mid.data", {32'd0, lane_data}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
